// File: rtl/vga_timing_detector.sv
// Rebuilds pixel position from incoming hsync/vsync, measures line/frame geometry and reports lock.
// Position lags the sync input by 2 cycles; no backpressure, one sample per clock.
module vga_timing_detector #(
  parameter int COUNTER_SIZE     = 11,
  parameter int LOCK_FRAMES      = 2,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic [COUNTER_SIZE-1:0] pixel_x,
  output logic [COUNTER_SIZE-1:0] pixel_y,
  output logic [COUNTER_SIZE-1:0] line_length,
  output logic [COUNTER_SIZE-1:0] frame_lines,
  output logic                    locked,
  output logic                    timing_error
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_TRACK   = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  localparam bit                    INVERT   = !SYNC_ACTIVE_HIGH;
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE = COUNTER_SIZE'(1);
  localparam logic [3:0]            LOCK_CNT = 4'(LOCK_FRAMES);

  state_t                  state_q, state_d;
  logic                    hs_r_q, hs_d_q, vs_r_q, vs_d_q;
  logic [COUNTER_SIZE-1:0] pixel_x_q, pixel_x_d;
  logic [COUNTER_SIZE-1:0] pixel_y_q, pixel_y_d;
  logic [COUNTER_SIZE-1:0] line_length_q, line_length_d;
  logic [COUNTER_SIZE-1:0] frame_lines_q, frame_lines_d;
  logic                    vpend_q, vpend_d;
  logic                    line_valid_q, line_valid_d;
  logic                    line_bad_q, line_bad_d;
  logic [3:0]              matches_q, matches_d;
  logic                    locked_q, locked_d;
  logic                    timing_error_q, timing_error_d;

  logic                    hedge, vedge, frame_start, sat, lmis, fmis;
  logic [COUNTER_SIZE-1:0] x_inc, y_inc;
  logic [3:0]              matches_inc;

  assign hedge       = hs_r_q & ~hs_d_q;
  assign vedge       = vs_r_q & ~vs_d_q;
  assign frame_start = hedge & (vpend_q | vedge);
  assign x_inc       = pixel_x_q + CNT_ONE;
  assign y_inc       = pixel_y_q + CNT_ONE;
  assign sat         = &pixel_x_q;
  assign lmis        = hedge & line_valid_q & (x_inc != line_length_q);
  assign fmis        = frame_start & (y_inc != frame_lines_q);
  assign matches_inc = matches_q + 4'd1;

  always_comb begin
    pixel_x_d      = hedge ? '0 : (sat ? pixel_x_q : x_inc);
    pixel_y_d      = pixel_y_q;
    line_length_d  = hedge ? x_inc : line_length_q;
    frame_lines_d  = frame_lines_q;
    vpend_d        = hedge ? 1'b0 : (vedge | vpend_q);
    line_valid_d   = line_valid_q | hedge;
    line_bad_d     = frame_start ? 1'b0 : (line_bad_q | lmis);
    matches_d      = matches_q;
    state_d        = state_q;
    timing_error_d = 1'b0;

    if (frame_start) begin
      pixel_y_d = '0;
    end else if (hedge && !(&pixel_y_q)) begin
      pixel_y_d = y_inc;
    end

    case (state_q)
      S_SEARCH: begin
        if (frame_start) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (frame_start) begin
          frame_lines_d = y_inc;
          matches_d     = '0;
          state_d       = S_TRACK;
        end
      end
      S_TRACK: begin
        if (frame_start) begin
          frame_lines_d = y_inc;
          // A line error on the frame-start edge itself still spoils this frame.
          if (line_bad_q | lmis | fmis) begin
            matches_d = '0;
          end else if (matches_inc == LOCK_CNT) begin
            matches_d = '0;
            state_d   = S_LOCKED;
          end else begin
            matches_d = matches_inc;
          end
        end
      end
      S_LOCKED: begin
        if (lmis | fmis) begin
          timing_error_d = 1'b1;
          matches_d      = '0;
          state_d        = S_TRACK;
          if (fmis) frame_lines_d = y_inc;
        end
      end
      default: state_d = S_SEARCH;
    endcase

    if (sat && state_q != S_SEARCH) begin
      state_d        = S_SEARCH;
      line_valid_d   = 1'b0;
      timing_error_d = (state_q == S_LOCKED);
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      state_q        <= S_SEARCH;
      hs_r_q         <= 1'b0;
      hs_d_q         <= 1'b0;
      vs_r_q         <= 1'b0;
      vs_d_q         <= 1'b0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      line_length_q  <= '0;
      frame_lines_q  <= '0;
      vpend_q        <= 1'b0;
      line_valid_q   <= 1'b0;
      line_bad_q     <= 1'b0;
      matches_q      <= '0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hs_r_q         <= hsync_in ^ INVERT;
      hs_d_q         <= hs_r_q;
      vs_r_q         <= vsync_in ^ INVERT;
      vs_d_q         <= vs_r_q;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      line_length_q  <= line_length_d;
      frame_lines_q  <= frame_lines_d;
      vpend_q        <= vpend_d;
      line_valid_q   <= line_valid_d;
      line_bad_q     <= line_bad_d;
      matches_q      <= matches_d;
      locked_q       <= locked_d;
      timing_error_q <= timing_error_d;
    end
  end

  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign line_length  = line_length_q;
  assign frame_lines  = frame_lines_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;

endmodule
